sram_bus_ctrl: RTL and testbench

SRAM responder that owns the external 1M×16 asynchronous SRAM pins and serves word read/write requests from two on-chip clients: client 0 is the effect chain (the delay/echo buffer), client 1 is the recorder/player. It arbitrates between the clients, sequences each access with fixed multi-cycle SRAM timing, drives the tristate data bus, and returns registered read data with a one-cycle acknowledge. It sits in the top level between the audio processing blocks and the board SRAM pins.

---
 rtl/sram_bus_ctrl_if.sv | 14 +
 rtl/sram_bus_ctrl.sv | 83 ++++++++
 tb/tb_sram_bus_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_bus_ctrl_if.sv
// sram_bus_ctrl_if: two-client word request/acknowledge handshake for sram_bus_ctrl.
interface sram_bus_ctrl_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic [1:0]             req;
    logic [1:0]             we_n;
    logic [1:0][ADDR_W-1:0] addr;
    logic [1:0][DATA_W-1:0] wdata;
    logic [1:0]             ack;
    logic [DATA_W-1:0]      rdata;
    modport master (output req, we_n, addr, wdata, input ack, rdata);
    modport slave (input req, we_n, addr, wdata, output ack, rdata);
endinterface

// File: rtl/sram_bus_ctrl.sv
// sram_bus_ctrl: two-client arbiter and sequencer for an asynchronous 1Mx16 SRAM.
// Define SRAM_ARB_RR_EN for round-robin arbitration; default is fixed priority to client 0.
module sram_bus_ctrl #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    sram_bus_ctrl_if.slave    bus,
    output logic [ADDR_W-1:0] o_SRAM_ADDR,
    inout  wire  [DATA_W-1:0] io_SRAM_DQ,
    output logic              o_SRAM_CE_N,
    output logic              o_SRAM_OE_N,
    output logic              o_SRAM_WE_N,
    output logic              o_SRAM_LB_N,
    output logic              o_SRAM_UB_N
);
    typedef enum logic [2:0] {IDLE, RD1, RD2, WR1, WR2, DONE} state_t;
    state_t state;
    logic gnt, pick, dq_oe;
    logic [DATA_W-1:0] dq;
`ifdef SRAM_ARB_RR_EN
    logic last;
    always_comb pick = &bus.req ? ~last : ~bus.req[0];
    always_ff @(posedge i_clk)
        if (i_rst) last <= 1'b1;
        else if (state == IDLE && |bus.req) last <= pick;
`else
    always_comb pick = ~bus.req[0];
`endif
    assign io_SRAM_DQ = dq_oe ? dq : 'z;
    // Pins are loaded one edge ahead so each state's pin values come straight from flops.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            gnt         <= 1'b0;
            bus.ack     <= '0;
            bus.rdata   <= '0;
            o_SRAM_ADDR <= '0;
            o_SRAM_CE_N <= 1'b1;
            o_SRAM_OE_N <= 1'b1;
            o_SRAM_WE_N <= 1'b1;
            o_SRAM_LB_N <= 1'b1;
            o_SRAM_UB_N <= 1'b1;
            dq_oe       <= 1'b0;
            dq          <= '0;
        end else begin
            bus.ack <= '0;
            case (state)
                IDLE: if (|bus.req) begin
                    gnt         <= pick;
                    o_SRAM_ADDR <= bus.addr[pick];
                    dq          <= bus.wdata[pick];
                    o_SRAM_CE_N <= 1'b0;
                    o_SRAM_LB_N <= 1'b0;
                    o_SRAM_UB_N <= 1'b0;
                    o_SRAM_OE_N <= ~bus.we_n[pick];
                    o_SRAM_WE_N <= bus.we_n[pick];
                    dq_oe       <= ~bus.we_n[pick];
                    state       <= bus.we_n[pick] ? RD1 : WR1;
                end
                RD1: state <= RD2;
                WR1: begin
                    o_SRAM_WE_N <= 1'b1;
                    state       <= WR2;
                end
                RD2, WR2: begin
                    if (state == RD2) bus.rdata <= io_SRAM_DQ;
                    bus.ack[gnt] <= 1'b1;
                    o_SRAM_ADDR  <= '0;
                    o_SRAM_CE_N  <= 1'b1;
                    o_SRAM_OE_N  <= 1'b1;
                    o_SRAM_WE_N  <= 1'b1;
                    o_SRAM_LB_N  <= 1'b1;
                    o_SRAM_UB_N  <= 1'b1;
                    dq_oe        <= 1'b0;
                    state        <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_bus_ctrl.sv
// tb_sram_bus_ctrl: scoreboard bench for sram_bus_ctrl with a behavioural SRAM on the pins.
module tb_sram_bus_ctrl;
    typedef struct {int k; logic rd; logic [15:0] data;} exp_t;
    typedef struct {logic we_n; logic [19:0] addr; logic [15:0] wdata;} op_t;
    logic i_clk = 1'b0, i_rst = 1'b0;
    logic [19:0] o_addr;
    wire  [15:0] dq;
    logic o_ce_n, o_oe_n, o_we_n, o_lb_n, o_ub_n;
    logic [15:0] mem [0:(1<<20)-1];
    exp_t sb[$];
    op_t ops0[$], ops1[$];
    int checks = 0, errors = 0, we_low = 0;
    logic [15:0] we_dq;
    bit mon_en = 1'b0;

    sram_bus_ctrl_if #(.ADDR_W(20), .DATA_W(16)) bus ();
    sram_bus_ctrl #(.ADDR_W(20), .DATA_W(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .bus(bus),
        .o_SRAM_ADDR(o_addr), .io_SRAM_DQ(dq),
        .o_SRAM_CE_N(o_ce_n), .o_SRAM_OE_N(o_oe_n), .o_SRAM_WE_N(o_we_n),
        .o_SRAM_LB_N(o_lb_n), .o_SRAM_UB_N(o_ub_n)
    );

    // SRAM drives reads; while deselected the bench holds a marker so stray controller drive shows up.
    assign dq = (!o_ce_n && !o_oe_n) ? mem[o_addr] : (o_ce_n ? 16'h5A5A : 'z);

    always #5 i_clk = ~i_clk;

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (!o_ce_n && !o_we_n) begin
                mem[o_addr] = dq;
                we_low++;
                we_dq = dq;
            end
            if (mon_en) begin
                checks++;
                if ((!o_oe_n && !o_we_n) || bus.ack == 2'b11 ||
                    (o_ce_n && (o_addr != 0 || dq !== 16'h5A5A || {o_oe_n, o_we_n, o_lb_n, o_ub_n} != 4'hF))) begin
                    errors++;
                    $display("FAIL pins got ce=%b oe=%b we=%b lb=%b ub=%b addr=%h dq=%h ack=%b", o_ce_n, o_oe_n, o_we_n, o_lb_n, o_ub_n, o_addr, dq, bus.ack);
                end
                if (bus.ack != 2'b00) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_extra got ack=%b want no ack", bus.ack);
                    end else begin
                        e = sb.pop_front();
                        if (bus.ack != (2'b01 << e.k) || (e.rd && bus.rdata !== e.data)) begin
                            errors++;
                            $display("FAIL sb got ack=%b rdata=%h want client %0d rd=%b rdata=%h", bus.ack, bus.rdata, e.k, e.rd, e.data);
                        end
                    end
                end
            end
        end
    endtask

    task automatic add_op(input int k, input logic we_n, input logic [19:0] a, input logic [15:0] d, input bit push);
        op_t o;
        exp_t e;
        o = '{we_n, a, d};
        if (k == 0) ops0.push_back(o); else ops1.push_back(o);
        e = '{k, we_n, d};
        if (push) sb.push_back(e);
    endtask

    task automatic run_client(input int k, input bit chk);
        op_t o;
        int n, want;
        want = 3;
        @(posedge i_clk); #1;
        while ((k == 0 ? ops0.size() : ops1.size()) != 0) begin
            o = (k == 0) ? ops0.pop_front() : ops1.pop_front();
            bus.req[k] = 1'b1;
            bus.we_n[k] = o.we_n;
            bus.addr[k] = o.addr;
            bus.wdata[k] = o.wdata;
            n = 0;
            do begin @(posedge i_clk); #1; n++; end while (!bus.ack[k] && n < 40);
            checks++;
            if (!bus.ack[k] || (chk && n != want)) begin
                errors++;
                $display("FAIL ack_lat c%0d got %0d cycles ack=%b want %0d", k, n, bus.ack[k], want);
            end
            want = 4;
        end
        bus.req[k] = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        checks += 5;
        if ({o_ce_n, o_oe_n, o_we_n, o_lb_n, o_ub_n} !== 5'h1F) begin errors++; $display("FAIL rst_ctl got %b want 11111", {o_ce_n, o_oe_n, o_we_n, o_lb_n, o_ub_n}); end
        if (o_addr !== 20'h0) begin errors++; $display("FAIL rst_addr got %h want 0", o_addr); end
        if (dq !== 16'h5A5A) begin errors++; $display("FAIL rst_dq got %h want released", dq); end
        if (bus.ack !== 2'b00) begin errors++; $display("FAIL rst_ack got %b want 00", bus.ack); end
        if (bus.rdata !== 16'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", bus.rdata); end
        i_rst = 1'b0;
    endtask

    task automatic test_write_read();
        we_low = 0;
        add_op(0, 1'b0, 20'd9000, 16'h1234, 1'b1);
        run_client(0, 1'b1);
        checks++;
        if (we_low != 1 || we_dq !== 16'h1234) begin
            errors++;
            $display("FAIL we_pulse got %0d cycles dq=%h want 1 cycle dq=1234", we_low, we_dq);
        end
        add_op(0, 1'b1, 20'd9000, 16'h1234, 1'b1);
        run_client(0, 1'b1);
    endtask

    task automatic test_ring_wrap();
        add_op(0, 1'b0, 20'd31999, 16'hBEEF, 1'b1);
        add_op(0, 1'b0, 20'd0, 16'h0F0F, 1'b1);
        add_op(0, 1'b1, 20'd31999, 16'hBEEF, 1'b1);
        add_op(0, 1'b1, 20'd0, 16'h0F0F, 1'b1);
        run_client(0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            mem[100 + i] = 16'hA100 + 16'(i);
            add_op(1, 1'b1, 20'(100 + i), 16'hA100 + 16'(i), 1'b1);
        end
        run_client(1, 1'b1);
    endtask

    task automatic test_simultaneous();
        exp_t e;
        test_reset();
        for (int i = 0; i < 4; i++) begin
            mem[200 + i] = 16'h2000 + 16'(i);
            mem[300 + i] = 16'h3000 + 16'(i);
            add_op(0, 1'b1, 20'(200 + i), 16'h2000 + 16'(i), 1'b0);
            add_op(1, 1'b1, 20'(300 + i), 16'h3000 + 16'(i), 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
`ifdef SRAM_ARB_RR_EN
            e = '{i % 2, 1'b1, (i % 2 == 0 ? 16'h2000 : 16'h3000) + 16'(i / 2)};
`else
            e = '{i / 4, 1'b1, (i < 4 ? 16'h2000 : 16'h3000) + 16'(i % 4)};
`endif
            sb.push_back(e);
        end
        fork
            run_client(0, 1'b0);
            run_client(1, 1'b0);
        join
    endtask

    task automatic test_reset_mid_write();
        @(posedge i_clk); #1;
        bus.we_n[0] = 1'b0;
        bus.addr[0] = 20'd5;
        bus.wdata[0] = 16'hDEAD;
        bus.req[0] = 1'b1;
        @(posedge i_clk); #1;
        checks++;
        if (o_we_n !== 1'b0) begin errors++; $display("FAIL wr1_we got %b want 0", o_we_n); end
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        checks += 3;
        if (o_we_n !== 1'b1 || o_ce_n !== 1'b1) begin errors++; $display("FAIL mid_rst_ctl got we=%b ce=%b want 1 1", o_we_n, o_ce_n); end
        if (dq !== 16'h5A5A) begin errors++; $display("FAIL mid_rst_dq got %h want released", dq); end
        if (bus.rdata !== 16'h0) begin errors++; $display("FAIL mid_rst_rdata got %h want 0", bus.rdata); end
        bus.req[0] = 1'b0;
        i_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge i_clk); #1;
            checks++;
            if (bus.ack !== 2'b00) begin errors++; $display("FAIL mid_rst_ack got %b want 00", bus.ack); end
        end
        add_op(0, 1'b0, 20'd5, 16'h5555, 1'b1);
        add_op(0, 1'b1, 20'd5, 16'h5555, 1'b1);
        run_client(0, 1'b1);
    endtask

    initial begin
        bus.req = '0;
        bus.we_n = '1;
        bus.addr = '0;
        bus.wdata = '0;
        fork monitor(); join_none
        test_reset();
        mon_en = 1'b1;
        test_write_read();
        test_ring_wrap();
        test_back_to_back();
        test_simultaneous();
        test_reset_mid_write();
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
